canonical_huffman_decoder: RTL and testbench
============================================

// Module: canonical_huffman_decoder
// PURPOSE
//  Bit-serial canonical Huffman decoder; receive-side counterpart of Canonical_Huffman_Machine.
//  Rebuilds the canonical code table from per-symbol code lengths.
//  Consumes the encoded bitstream one bit per cycle and emits decoded symbols over valid/ready.
//  Sits after the encoder in the loopback bench to prove encode/decode round-trips.
// PARAMETERS
//  NSYM    10  number of symbols in the alphabet
//  LEN_W   4   width of each code-length field; length 0 = symbol unused
//  MAXLEN  9   longest legal code length in bits
//  SYM_W   4   symbol index width, >= clog2(NSYM)
// PORTS
//  clk        in   1            single clock, rising edge
//  reset      in   1            asynchronous, active-high
//  cfg_start  in   1            pulse: latch cfg_lens and rebuild the table
//  cfg_lens   in   NSYM*LEN_W   code length of symbol s at [s*LEN_W +: LEN_W]
//  tbl_ready  out  1            table valid, decoder accepting bits
//  bit_valid  in   1            bit_in valid
//  bit_in     in   1            next code bit, MSB-first per codeword
//  bit_ready  out  1            decoder accepts bit this cycle
//  sym_valid  out  1            sym_out holds a decoded symbol
//  sym_out    out  SYM_W        decoded symbol index
//  sym_ready  in   1            downstream accepts symbol
//  err        out  1            invalid code detected (HUFF_DEC_ERR_EN only; otherwise tied 0)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counts, first-code, offset and sym_tab cleared.
//  States: IDLE -> BUILD -> FINAL -> DECODE.
//  - cfg_start in any state: latch cfg_lens, clear tables, acc, err and sym_valid, go to BUILD.
//  BUILD: nested scan of len l = 1..MAXLEN (outer) and symbol s = 0..NSYM-1 (inner); one (l,s) per cycle.
//  - If lens[s] == l: sym_tab[wp] <= s; wp++; cnt[l]++.
//  - At row start: off[l] <= wp.
//  - first[1] = 0; first[l+1] = (first[l] + cnt[l]) << 1, computed at row end.
//  - Latency from cfg_start: exactly NSYM*MAXLEN BUILD cycles, plus 1 FINAL cycle.
//  - tbl_ready rises on DECODE entry (cycle 91 with defaults).
//  DECODE:
//  - bit_ready = tbl_ready & ~sym_valid & ~err.
//  - A bit is accepted when bit_valid & bit_ready: acc <= {acc, bit_in}; len <= len + 1.
//  - Match when (acc_new - first[len_new]) < cnt[len_new], using (MAXLEN+1)-bit unsigned compare.
//  - On match, the next cycle gives sym_valid = 1 and sym_out = sym_tab[off[len] + acc - first[len]]; acc and len clear.
//  - sym_out is held stable until sym_valid & sym_ready; no bits are accepted while sym_valid = 1.
//  - Symbol latency: 1 cycle after the final bit of the code is accepted.
//  - Max throughput: one symbol per (code length + 1) cycles.
//  Boundaries:
//  - len reaches MAXLEN with no match (incomplete or invalid codebook): overflow, see CONFIGURATION.
//  - All lengths 0: the table is empty and every code overflows.
//  - One used symbol of length 1: code '0' decodes; '1' overflows.
//  - bit_valid with tbl_ready = 0 is ignored (bit_ready = 0).
//  - cfg_start together with bit_valid: cfg_start wins; the bit is not consumed.
//  - Reset mid-BUILD or mid-code: everything is discarded and the block returns to IDLE.
//  - Codebook is not checked for Kraft validity; over-subscribed sets give undefined symbols but must not hang.
// CONFIGURATION
//  HUFF_DEC_ERR_EN defined:
//  - Overflow sets err = 1 (sticky) and forces bit_ready = 0; only cfg_start or reset clears it.
//  HUFF_DEC_ERR_EN undefined:
//  - err is tied 0; on overflow, acc and len clear silently and decoding resumes with the next bit.
// TESTING
//  1. Default params, lens s0=2, s1=1, s2=3, s3=3, others 0; cfg_start.
//     -> tbl_ready high exactly 91 cycles later.
//     -> Codes: s1=0, s0=10, s2=110, s3=111.
//  2. Table from test 1, stream 0,1,0,1,1,0,1,1,1 with sym_ready = 1.
//     -> Symbols 1, 0, 2, 3 in order; each appears 1 cycle after its last bit.
//  3. Test 2 stream with sym_ready held 0 for 5 cycles after first symbol.
//     -> sym_out = 1 stays stable, bit_ready = 0, no bits lost.
//  4. Lens s0=1 only; stream 1 x9.
//     -> ERR_EN: err = 1 after 9th bit, bit_ready = 0.
//     -> No ERR_EN: no symbol; a following '0' decodes s0.
//  5. cfg_start after 2 bits of a '110' code, new lens all 4.
//     -> Partial code dropped; codes 0000..1001 map to s0..s9.
//  6. Assert reset mid-BUILD.
//     -> All outputs 0 immediately (async).
//     -> Decoding blocked until the next cfg_start.

Source files
------------

// File: rtl/canonical_huffman_decoder.sv
// rtl/canonical_huffman_decoder.sv - bit-serial canonical Huffman decoder with table rebuild from code lengths
// Define HUFF_DEC_ERR_EN for a sticky overflow error; otherwise overflowing codes are dropped silently.
module canonical_huffman_decoder #(
  parameter int NSYM   = 10,
  parameter int LEN_W  = 4,
  parameter int MAXLEN = 9,
  parameter int SYM_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [NSYM*LEN_W-1:0] cfg_lens,
  output logic                  tbl_ready,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic                  bit_ready,
  output logic                  sym_valid,
  output logic [SYM_W-1:0]      sym_out,
  input  logic                  sym_ready,
  output logic                  err
);
  localparam int CW = $clog2(NSYM + 1);
  localparam int LW = $clog2(MAXLEN + 1);
  localparam int SW = $clog2(NSYM);
  localparam int AW = MAXLEN + 1;

  typedef enum logic [1:0] {IDLE, BUILD, FINAL, DECODE} state_t;
  state_t state, state_nxt;

  logic [NSYM*LEN_W-1:0] lens;
  logic [CW-1:0]         cnt     [0:MAXLEN];
  logic [CW-1:0]         off     [0:MAXLEN];
  logic [AW-1:0]         first   [0:MAXLEN];
  logic [SYM_W-1:0]      sym_tab [NSYM];
  logic [CW-1:0]         wp;
  logic [LW-1:0]         bl;
  logic [SW-1:0]         bs;
  logic [MAXLEN-2:0]     acc;
  logic [LW-1:0]         len;
  logic                  err_q;

  // Build scan: row bl is the code length, column bs the symbol.
  logic [LEN_W-1:0] cur_len;
  logic             hit, row_end, build_last;
  logic [CW-1:0]    cnt_row;
  logic [LW-1:0]    bl_nx;

  assign cur_len    = lens[32'(bs)*LEN_W +: LEN_W];
  assign hit        = (32'(cur_len) == 32'(bl));
  assign row_end    = (bs == SW'(NSYM - 1));
  assign build_last = row_end && (bl == LW'(MAXLEN));
  assign cnt_row    = cnt[bl] + CW'(hit);
  assign bl_nx      = bl + LW'(1);

  logic [MAXLEN-1:0] acc_new;
  logic [LW-1:0]     len_new;
  logic [AW-1:0]     diff, tab_idx;
  logic              match, accept;
  logic [SYM_W-1:0]  sym_sel;

  assign acc_new = {acc, bit_in};
  assign len_new = len + LW'(1);
  assign diff    = {1'b0, acc_new} - first[len_new];
  assign match   = diff < AW'(cnt[len_new]);
  assign tab_idx = AW'(off[len_new]) + diff;
  // Over-subscribed codebooks can index past the table; return symbol 0 there.
  assign sym_sel = (tab_idx < AW'(NSYM)) ? sym_tab[tab_idx[SW-1:0]] : '0;

`ifdef HUFF_DEC_ERR_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign tbl_ready = (state == DECODE);
  assign bit_ready = tbl_ready & ~sym_valid & ~err & ~cfg_start;
  assign accept    = bit_valid & bit_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cfg_start) begin
      state_nxt = BUILD;
    end else begin
      case (state)
        BUILD:   if (build_last) state_nxt = FINAL;
        FINAL:   state_nxt = DECODE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lens      <= '0;
      wp        <= '0;
      bl        <= LW'(1);
      bs        <= '0;
      acc       <= '0;
      len       <= '0;
      sym_valid <= 1'b0;
      sym_out   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i <= MAXLEN; i++) begin
        cnt[i]   <= '0;
        off[i]   <= '0;
        first[i] <= '0;
      end
      for (int i = 0; i < NSYM; i++) sym_tab[i] <= '0;
    end else if (cfg_start) begin
      lens      <= cfg_lens;
      wp        <= '0;
      bl        <= LW'(1);
      bs        <= '0;
      acc       <= '0;
      len       <= '0;
      sym_valid <= 1'b0;
      sym_out   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i <= MAXLEN; i++) begin
        cnt[i]   <= '0;
        off[i]   <= '0;
        first[i] <= '0;
      end
      for (int i = 0; i < NSYM; i++) sym_tab[i] <= '0;
    end else begin
      case (state)
        BUILD: begin
          if (bs == '0) off[bl] <= wp;
          if (hit) begin
            sym_tab[wp[SW-1:0]] <= SYM_W'(bs);
            wp                  <= wp + CW'(1);
            cnt[bl]             <= cnt_row;
          end
          if (row_end) begin
            if (bl != LW'(MAXLEN)) first[bl_nx] <= (first[bl] + AW'(cnt_row)) << 1;
            bs <= '0;
            bl <= bl_nx;
          end else begin
            bs <= bs + SW'(1);
          end
        end
        DECODE: begin
          if (sym_valid && sym_ready) sym_valid <= 1'b0;
          if (accept) begin
            if (match) begin
              sym_valid <= 1'b1;
              sym_out   <= sym_sel;
              acc       <= '0;
              len       <= '0;
            end else if (len_new == LW'(MAXLEN)) begin
              acc <= '0;
              len <= '0;
`ifdef HUFF_DEC_ERR_EN
              err_q <= 1'b1;
`endif
            end else begin
              acc <= acc_new[MAXLEN-2:0];
              len <= len_new;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// tb/tb_canonical_huffman_decoder.sv - self-checking bench for canonical_huffman_decoder
// Codeword-level reference model compared every cycle, plus literal expectations for codes and symbol streams.
module tb_canonical_huffman_decoder;
  localparam int NSYM = 10, LEN_W = 4, MAXLEN = 9, SYM_W = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  cfg_start, bit_valid, bit_in, sym_ready;
  logic [NSYM*LEN_W-1:0] cfg_lens;
  logic                  tbl_ready, bit_ready, sym_valid, err;
  logic [SYM_W-1:0]      sym_out;

  int n_checks = 0, n_pass = 0;
  int got[$];
  int exp_q[$];

  always #5 clk = ~clk;

  canonical_huffman_decoder #(.NSYM(NSYM), .LEN_W(LEN_W), .MAXLEN(MAXLEN), .SYM_W(SYM_W)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_lens(cfg_lens),
    .tbl_ready(tbl_ready), .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_out(sym_out), .sym_ready(sym_ready), .err(err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: per-symbol canonical codes, matched against the bits seen so far.
  int m_code[NSYM], m_clen[NSYM];
  int m_build = 0, m_sym = 0, m_acc = 0, m_n = 0;
  bit m_tbl = 0, m_sv = 0, m_err = 0;

  function automatic void m_load(input logic [NSYM*LEN_W-1:0] l);
    int bl_count[MAXLEN+1];
    int next_code[MAXLEN+1];
    int code;
    for (int b = 0; b <= MAXLEN; b++) bl_count[b] = 0;
    for (int s = 0; s < NSYM; s++) begin
      m_clen[s] = int'(l[s*LEN_W +: LEN_W]);
      if (m_clen[s] > MAXLEN) m_clen[s] = 0;
      if (m_clen[s] > 0) bl_count[m_clen[s]]++;
    end
    code = 0;
    next_code[0] = 0;
    for (int b = 1; b <= MAXLEN; b++) begin
      code = (code + bl_count[b-1]) << 1;
      next_code[b] = code;
    end
    for (int s = 0; s < NSYM; s++) begin
      m_code[s] = -1;
      if (m_clen[s] > 0) begin
        m_code[s] = next_code[m_clen[s]];
        next_code[m_clen[s]]++;
      end
    end
  endfunction

  function automatic bit m_br();
    return m_tbl && !m_sv && !m_err && !cfg_start;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_build = 0; m_tbl = 0; m_sv = 0; m_err = 0; m_sym = 0; m_acc = 0; m_n = 0;
    end else begin
      bit br;
      bit found;
      br = m_br();
      if (cfg_start) begin
        m_load(cfg_lens);
        m_build = NSYM * MAXLEN + 1;
        m_tbl = 0; m_sv = 0; m_err = 0; m_sym = 0; m_acc = 0; m_n = 0;
      end else begin
        if (m_build > 0) begin
          m_build--;
          if (m_build == 0) m_tbl = 1;
        end
        if (m_sv && sym_ready) m_sv = 0;
        if (bit_valid && br) begin
          m_acc = m_acc * 2 + int'(bit_in);
          m_n++;
          found = 0;
          for (int s = 0; s < NSYM; s++)
            if (!found && m_clen[s] == m_n && m_code[s] == m_acc) begin
              found = 1; m_sym = s;
            end
          if (found) begin
            m_sv = 1; m_acc = 0; m_n = 0;
          end else if (m_n == MAXLEN) begin
            m_acc = 0; m_n = 0;
`ifdef HUFF_DEC_ERR_EN
            m_err = 1;
`endif
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("tbl_ready", tbl_ready, m_tbl);
    check("bit_ready", bit_ready, m_br());
    check("sym_valid", sym_valid, m_sv);
    if (m_sv) check("sym_out", sym_out, m_sym);
    check("err", err, m_err);
    if (sym_valid && sym_ready) got.push_back(int'(sym_out));
  end

  task automatic do_cfg(input logic [NSYM*LEN_W-1:0] l, input bit with_bit);
    cfg_lens = l; cfg_start = 1; bit_valid = with_bit; bit_in = 0;
    @(posedge clk); #1;
    cfg_start = 0; bit_valid = 0;
  endtask

  task automatic wait_tbl(input string name);
    int cyc = 0;
    while (!tbl_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check(name, cyc, 91);
  endtask

  task automatic send_bits(input string s);
    logic ok;
    for (int i = 0; i < s.len(); i++) begin
      int t = 0;
      bit_valid = 1; bit_in = (s[i] == "1");
      do begin
        @(negedge clk); ok = bit_ready;
        @(posedge clk); #1; t++;
      end while (!ok && t < 100);
      if (!ok) check("bit_accept", ok, 1);
    end
    bit_valid = 0;
  endtask

  task automatic check_syms(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_q[i]);
  endtask

  logic [NSYM*LEN_W-1:0] l1, l4, l5;

  initial begin
    cfg_start = 0; cfg_lens = '0; bit_valid = 0; bit_in = 0; sym_ready = 1;
    repeat (2) @(posedge clk); #1 reset = 0;
    check("rst_tbl_ready", tbl_ready, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_out", sym_out, 0);

    // Test 1: table build latency and codes
    l1 = '0;
    l1[0*LEN_W +: LEN_W] = 4'd2; l1[1*LEN_W +: LEN_W] = 4'd1;
    l1[2*LEN_W +: LEN_W] = 4'd3; l1[3*LEN_W +: LEN_W] = 4'd3;
    do_cfg(l1, 0);
    wait_tbl("t1_latency");
    check("code_s1", m_code[1], 0); check("clen_s1", m_clen[1], 1);
    check("code_s0", m_code[0], 2); check("clen_s0", m_clen[0], 2);
    check("code_s2", m_code[2], 6); check("clen_s2", m_clen[2], 3);
    check("code_s3", m_code[3], 7); check("clen_s3", m_clen[3], 3);

    // Test 2: free-flowing stream
    got.delete(); exp_q = '{1, 0, 2, 3};
    send_bits("010110111");
    repeat (4) @(posedge clk); #1;
    check_syms("t2");

    // Test 3: downstream stall after the first symbol
    got.delete(); sym_ready = 0;
    fork
      send_bits("010110111");
      begin
        for (int t = 0; t < 100 && !sym_valid; t++) @(negedge clk);
        check("t3_first_valid", sym_valid, 1);
        repeat (5) @(posedge clk);
        #1 sym_ready = 1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check_syms("t3");

    // Test 4: single length-1 symbol, overflow on all-ones
    l4 = '0; l4[0 +: LEN_W] = 4'd1;
    do_cfg(l4, 0);
    wait_tbl("t4_latency");
    got.delete();
    send_bits("111111111");
    repeat (3) @(posedge clk); #1;
    check("t4_nosym", got.size(), 0);
`ifdef HUFF_DEC_ERR_EN
    check("t4_err", err, 1);
    check("t4_bit_ready", bit_ready, 0);
`else
    check("t4_err", err, 0);
    exp_q = '{0};
    send_bits("0");
    repeat (3) @(posedge clk); #1;
    check_syms("t4");
`endif

    // Test 5: reconfigure mid-code, with a bit offered alongside cfg_start
    do_cfg(l1, 0);
    wait_tbl("t5a_latency");
    got.delete();
    send_bits("11");
    for (int s = 0; s < NSYM; s++) l5[s*LEN_W +: LEN_W] = 4'd4;
    do_cfg(l5, 1);
    wait_tbl("t5_latency");
    check("t5_nosym", got.size(), 0);
    exp_q.delete();
    for (int s = 0; s < NSYM; s++) exp_q.push_back(s);
    send_bits("0000000100100011010001010110011110001001");
    repeat (4) @(posedge clk); #1;
    check_syms("t5");

    // Test 6: asynchronous reset with a pending symbol, then mid-build
    sym_ready = 0;
    send_bits("0000");
    @(posedge clk); #3 reset = 1;
    #1;
    check("t6a_sym_valid", sym_valid, 0);
    check("t6a_tbl_ready", tbl_ready, 0);
    check("t6a_bit_ready", bit_ready, 0);
    check("t6a_sym_out", sym_out, 0);
    @(posedge clk); #1 reset = 0; sym_ready = 1;
    do_cfg(l1, 0);
    repeat (30) @(posedge clk);
    #3 reset = 1;
    #1;
    check("t6b_tbl_ready", tbl_ready, 0);
    check("t6b_sym_valid", sym_valid, 0);
    check("t6b_err", err, 0);
    @(posedge clk); #1 reset = 0;
    got.delete();
    bit_valid = 1; bit_in = 0;
    repeat (120) @(posedge clk);
    #1 bit_valid = 0;
    check("t6_blocked_tbl", tbl_ready, 0);
    check("t6_blocked_nosym", got.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
